// File: rtl/rst_gen_pkg.sv
// Shared types for the reset generator: FSM state and reset-cause encodings.
package rst_gen_pkg;

  typedef enum logic [1:0] {
    S_POR  = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_WAIT = 2'd3
  } rst_gen_state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_BTN = 2'd1,
    CAUSE_WDT = 2'd2
  } rst_cause_t;

endpackage

// File: rtl/btn_deb.sv
// Push-button conditioner: 2-FF synchroniser plus saturating low/high run counters
// producing a one-cycle press pulse and a level released flag.
module btn_deb #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_n_i,
  output logic press,
  output logic released
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic          sync1_r;
  logic          sync2_r;
  logic          btn_s;
  logic [CW-1:0] low_cnt_r;
  logic [CW-1:0] high_cnt_r;
  logic          press_r;

  // Synchroniser resets high so an idle button never looks pressed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= btn_n_i;
      sync2_r <= sync1_r;
    end
  end

  assign btn_s = sync2_r;

  // Run-length counters; press fires on the edge the low run becomes exactly DEBOUNCE_CYCLES.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      low_cnt_r  <= CNT_ZERO;
      high_cnt_r <= CNT_ZERO;
      press_r    <= 1'b0;
    end else begin
      if (btn_s) begin
        low_cnt_r <= CNT_ZERO;
      end else if (low_cnt_r != CNT_MAX) begin
        low_cnt_r <= low_cnt_r + CNT_ONE;
      end else begin
        low_cnt_r <= low_cnt_r;
      end

      if (!btn_s) begin
        high_cnt_r <= CNT_ZERO;
      end else if (high_cnt_r != CNT_MAX) begin
        high_cnt_r <= high_cnt_r + CNT_ONE;
      end else begin
        high_cnt_r <= high_cnt_r;
      end

      press_r <= !btn_s && (low_cnt_r == CNT_PRE);
    end
  end

  assign press    = press_r;
  assign released = (high_cnt_r == CNT_MAX);

endmodule

// File: rtl/rst_gen.sv
// Reset generator: POR stretch, debounced button reset and optional watchdog,
// with minimum reset width and last-cause reporting. Watchdog enabled by RST_GEN_WDT_EN.
module rst_gen
  import rst_gen_pkg::*;
#(
  parameter int unsigned POR_CYCLES      = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 4096,
  parameter int unsigned WDT_CYCLES      = 50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       btn_n_i,
`ifdef RST_GEN_WDT_EN
  input  logic       wdt_kick_i,
`endif
  output logic       rst_n_o,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned POR_W  = $clog2(POR_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_CYCLES);
  localparam logic [POR_W-1:0]  POR_ONE   = POR_W'(1);
  localparam logic [POR_W-1:0]  POR_ZERO  = POR_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

  rst_gen_state_t    state_r;
  rst_gen_state_t    state_nxt_s;
  rst_cause_t        cause_r;
  rst_cause_t        cause_nxt_s;
  logic              rst_n_r;
  logic [POR_W-1:0]  por_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              press_s;
  logic              released_s;
  logic              wdt_to_s;

  btn_deb #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_deb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .btn_n_i  (btn_n_i),
    .press    (press_s),
    .released (released_s)
  );

`ifdef RST_GEN_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);
  localparam logic [WDT_W-1:0] WDT_ZERO = WDT_W'(0);

  logic [WDT_W-1:0] wdt_cnt_r;

  // Watchdog counts RUN cycles since RUN entry or the last kick.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdt_cnt_r <= WDT_ZERO;
    end else if ((state_r == S_RUN) && (state_nxt_s == S_RUN) && !wdt_kick_i) begin
      wdt_cnt_r <= wdt_cnt_r + WDT_ONE;
    end else begin
      wdt_cnt_r <= WDT_ZERO;
    end
  end

  // A kick in the terminal-count cycle suppresses the timeout.
  assign wdt_to_s = (state_r == S_RUN) && (wdt_cnt_r == WDT_LAST) && !wdt_kick_i;
`else
  assign wdt_to_s = 1'b0;
`endif

  // Next-state and cause selection; button has priority over watchdog.
  always_comb begin
    state_nxt_s = state_r;
    cause_nxt_s = cause_r;
    case (state_r)
      S_POR: begin
        if (por_cnt_r == POR_LAST) state_nxt_s = S_RUN;
        else                       state_nxt_s = S_POR;
      end
      S_RUN: begin
        if (press_s) begin
          state_nxt_s = S_HOLD;
          cause_nxt_s = CAUSE_BTN;
        end else if (wdt_to_s) begin
          state_nxt_s = S_HOLD;
          cause_nxt_s = CAUSE_WDT;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) state_nxt_s = S_WAIT;
        else                         state_nxt_s = S_HOLD;
      end
      S_WAIT: begin
        if (released_s) state_nxt_s = S_RUN;
        else            state_nxt_s = S_WAIT;
      end
      default: begin
        state_nxt_s = S_POR;
        cause_nxt_s = CAUSE_POR;
      end
    endcase
  end

  // State, interval counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= S_POR;
      cause_r    <= CAUSE_POR;
      rst_n_r    <= 1'b0;
      por_cnt_r  <= POR_ZERO;
      hold_cnt_r <= HOLD_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cause_r <= cause_nxt_s;
      rst_n_r <= (state_nxt_s == S_RUN);

      if ((state_r == S_POR) && (state_nxt_s == S_POR)) por_cnt_r <= por_cnt_r + POR_ONE;
      else                                              por_cnt_r <= POR_ZERO;

      if ((state_r == S_HOLD) && (state_nxt_s == S_HOLD)) hold_cnt_r <= hold_cnt_r + HOLD_ONE;
      else                                                hold_cnt_r <= HOLD_ZERO;
    end
  end

  assign rst_n_o     = rst_n_r;
  assign rst_cause_o = cause_r;

endmodule

// File: tb/tb_rst_gen.sv
// Self-checking bench for rst_gen: directed scenarios plus random button/kick/reset
// traffic compared each cycle against a history-based reference model.
module tb_rst_gen;

  localparam int POR  = 8;
  localparam int DEB  = 4;
  localparam int HOLD = 6;
  localparam int WDT  = 20;

  localparam int M_POR = 0;
  localparam int M_RUN = 1;
  localparam int M_LOW = 2;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       btn_n_i;
`ifdef RST_GEN_WDT_EN
  logic       wdt_kick_i;
`endif
  logic       rst_n_o;
  logic [1:0] rst_cause_o;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";
  int    cyc    = 0;
  bit    auto_kick = 1'b1;

  // Reference model: button samples since reset, with the two synchroniser reset ones in front.
  bit q[$];
  int e;
  int m_mode;
  int m_out;
  int m_cause;
  int low_start;
  int ref_e;

  int  seg_len;
  bit  seg_lvl;
  int  rlen;

  always #5 clk = ~clk;

  rst_gen #(
    .POR_CYCLES      (POR),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .WDT_CYCLES      (WDT)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .btn_n_i     (btn_n_i),
`ifdef RST_GEN_WDT_EN
    .wdt_kick_i  (wdt_kick_i),
`endif
    .rst_n_o     (rst_n_o),
    .rst_cause_o (rst_cause_o)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Length (capped at lim) of the run of value v in the sample history ending at sample j.
  function automatic int run_len(input int j, input bit v, input int lim);
    int n;
    int k;
    n = 0;
    k = j + 1;
    while (k >= 0 && k < q.size() && n < lim && q[k] == v) begin
      n++;
      k--;
    end
    return n;
  endfunction

  task automatic model_step(input bit r, input bit b, input bit k);
    bit press;
    bit rel;
    bit wdt_to;
    if (!r) begin
      q = '{1'b1, 1'b1};
      e = 0;
      m_mode = M_POR;
      m_out = 0;
      m_cause = 0;
    end else begin
      e++;
      q.push_back(b);
      press = (run_len(e - 3, 1'b0, DEB + 1) == DEB);
      rel   = (run_len(e - 3, 1'b1, DEB) == DEB);
`ifdef RST_GEN_WDT_EN
      wdt_to = !k && (e - ref_e == WDT + 1);
`else
      wdt_to = 1'b0;
`endif
      case (m_mode)
        M_POR: begin
          if (e == POR + 1) begin
            m_mode = M_RUN; m_out = 1; ref_e = e;
          end
        end
        M_RUN: begin
          if (press) begin
            m_mode = M_LOW; m_out = 0; m_cause = 1; low_start = e;
          end else if (wdt_to) begin
            m_mode = M_LOW; m_out = 0; m_cause = 2; low_start = e;
          end else if (k) begin
            ref_e = e;
          end
        end
        default: begin
          if ((e - low_start >= HOLD + 1) && rel) begin
            m_mode = M_RUN; m_out = 1; ref_e = e;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit r, input bit b, input bit k);
    rst_n_i = r;
    btn_n_i = b;
`ifdef RST_GEN_WDT_EN
    wdt_kick_i = k;
`endif
    @(posedge clk);
    model_step(r, b, k);
    cyc++;
    @(negedge clk);
    check_eq({phase, ":rst_n_o"}, int'(rst_n_o), m_out);
    check_eq({phase, ":cause"}, int'(rst_cause_o), m_cause);
  endtask

  task automatic hold(input int n, input bit r, input bit b);
    for (int i = 0; i < n; i++) step(r, b, auto_kick && (cyc % 10 == 0));
  endtask

  initial begin
    rst_n_i = 1'b0;
    btn_n_i = 1'b1;
`ifdef RST_GEN_WDT_EN
    wdt_kick_i = 1'b0;
`endif
    q = '{1'b1, 1'b1};
    e = 0; m_mode = M_POR; m_out = 0; m_cause = 0; low_start = 0; ref_e = 0;

    phase = "reset";
    hold(3, 1'b0, 1'b1);
    check_eq("reset_rst_n_o", int'(rst_n_o), 0);
    check_eq("reset_cause", int'(rst_cause_o), 0);

    phase = "por";
    hold(5, 1'b1, 1'b1);
    hold(2, 1'b0, 1'b1);
    hold(POR, 1'b1, 1'b1);
    check_eq("por_still_low", int'(rst_n_o), 0);
    hold(1, 1'b1, 1'b1);
    check_eq("por_release", int'(rst_n_o), 1);
    hold(5, 1'b1, 1'b1);

    phase = "bounce";
    hold(3, 1'b1, 1'b0);
    hold(1, 1'b1, 1'b1);
    hold(3, 1'b1, 1'b0);
    hold(8, 1'b1, 1'b1);
    check_eq("bounce_no_reset", int'(rst_n_o), 1);
    hold(DEB + 2, 1'b1, 1'b0);
    check_eq("press_not_yet", int'(rst_n_o), 1);
    hold(1, 1'b1, 1'b0);
    check_eq("press_falls", int'(rst_n_o), 0);
    check_eq("press_cause", int'(rst_cause_o), 1);
    hold(13, 1'b1, 1'b0);
    hold(20, 1'b1, 1'b1);

    phase = "hold";
    hold(DEB, 1'b1, 1'b0);
    hold(25, 1'b1, 1'b1);

    phase = "long";
    hold(100, 1'b1, 1'b0);
    hold(20, 1'b1, 1'b1);

`ifdef RST_GEN_WDT_EN
    auto_kick = 1'b0;
    phase = "wdt_kick15";
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1);
      hold(14, 1'b1, 1'b1);
    end
    phase = "wdt_timeout";
    step(1'b1, 1'b1, 1'b1);
    hold(WDT, 1'b1, 1'b1);
    check_eq("wdt_before_to", int'(rst_n_o), 1);
    hold(1, 1'b1, 1'b1);
    check_eq("wdt_falls", int'(rst_n_o), 0);
    check_eq("wdt_cause", int'(rst_cause_o), 2);
    hold(12, 1'b1, 1'b1);
    phase = "wdt_terminal_kick";
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1);
      hold(WDT, 1'b1, 1'b1);
    end
    step(1'b1, 1'b1, 1'b1);
    check_eq("wdt_terminal_kick", int'(rst_n_o), 1);
    phase = "simultaneous";
    hold(14, 1'b1, 1'b1);
    hold(10, 1'b1, 1'b0);
    check_eq("simul_cause", int'(rst_cause_o), 1);
    auto_kick = 1'b1;
    hold(2, 1'b0, 1'b0);
    check_eq("simul_abort_cause", int'(rst_cause_o), 0);
`endif

    phase = "hold_abort";
    hold(20, 1'b1, 1'b1);
    hold(DEB + 5, 1'b1, 1'b0);
    check_eq("hold_cause", int'(rst_cause_o), 1);
    rst_n_i = 1'b0;
    #1;
    check_eq("async_abort_rst_n_o", int'(rst_n_o), 0);
    check_eq("async_abort_cause", int'(rst_cause_o), 0);
    hold(2, 1'b0, 1'b0);
    hold(POR + 10, 1'b1, 1'b1);

    phase = "random";
    auto_kick = 1'b0;
    for (int s = 0; s < 250; s++) begin
      seg_len = $urandom_range(1, 9);
      seg_lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 60) == 0) begin
        rlen = $urandom_range(1, 3);
        for (int i = 0; i < rlen; i++) step(1'b0, seg_lvl, 1'b0);
      end
      for (int i = 0; i < seg_len; i++) step(1'b1, seg_lvl, ($urandom_range(0, 17) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
